// File: rtl/ctrl_decode_pipe.sv
// Main control unit: RV32I (+ optional M) decode registered into the ID/EX stage,
// with load-use hazard detection, multi-cycle MUL/DIV occupancy of EX and branch flush.
module ctrl_decode_pipe #(
  parameter bit          EN_MEXT    = 1'b1,
  parameter int unsigned MUL_CYCLES = 1,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic        flush,
  output logic        stall_id,
  output logic        ex_valid,
  output logic [2:0]  ex_imm_type,
  output logic [2:0]  ex_alu_op,
  output logic        ex_pc_to_reg_src,
  output logic        ex_rd_src,
  output logic        ex_alu_src,
  output logic        ex_mem_to_reg,
  output logic        ex_mem_write,
  output logic        ex_mem_read,
  output logic        ex_reg_write,
  output logic [1:0]  ex_branch,
  output logic [4:0]  ex_rd,
  output logic        ex_illegal,
  output logic        md_busy
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] F7Mext    = 7'b0000001;

  localparam logic [2:0] AluR = 3'd0, AluI = 3'd1, AluAdd = 3'd2, AluJalr = 3'd3;
  localparam logic [2:0] AluB = 3'd4, AluLui = 3'd5, AluMd = 3'd6;

  // Counter preload is N-1: the load edge itself accounts for the first EX cycle.
  localparam logic [5:0] MulLoad = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DivLoad = 6'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {StRun, StMdWait} state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] imm_type;
    logic [2:0] alu_op;
    logic       pc_to_reg_src;
    logic       rd_src;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic [1:0] branch;
    logic [4:0] rd;
    logic       illegal;
  } bundle_t;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  bundle_t    ex_q, ex_d;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2;
  logic       unused_funct3;
  bundle_t    dec;
  logic       dec_md;
  logic       use_rs1, use_rs2;
  logic       hazard;
  logic [5:0] md_load;

  assign opcode        = id_inst[6:0];
  assign funct7        = id_inst[31:25];
  assign rs1           = id_inst[19:15];
  assign rs2           = id_inst[24:20];
  assign unused_funct3 = ^id_inst[13:12];

  // Decode the ID instruction into the EX control bundle.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec_md    = 1'b0;
    case (opcode)
      OpcOp: begin
        if (funct7 == F7Mext && !EN_MEXT) begin
          dec.illegal = 1'b1;
        end else begin
          dec_md        = (funct7 == F7Mext);
          dec.alu_op    = dec_md ? AluMd : AluR;
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
        end
      end
      OpcLoad: begin
        dec.alu_op     = AluAdd;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OpcOpImm: begin
        dec.alu_op    = AluI;
        dec.reg_write = 1'b1;
      end
      OpcJalr: begin
        dec.alu_op    = AluJalr;
        dec.rd_src    = 1'b1;
        dec.reg_write = 1'b1;
        dec.branch    = 2'd2;
      end
      OpcStore: begin
        dec.imm_type  = 3'd1;
        dec.alu_op    = AluAdd;
        dec.mem_write = 1'b1;
      end
      OpcBranch: begin
        dec.imm_type = 3'd2;
        dec.alu_op   = AluB;
        dec.alu_src  = 1'b1;
        dec.branch   = 2'd1;
      end
      OpcAuipc: begin
        dec.imm_type      = 3'd3;
        dec.alu_op        = AluAdd;
        dec.pc_to_reg_src = 1'b1;
        dec.alu_src       = 1'b1;
        dec.rd_src        = 1'b1;
        dec.reg_write     = 1'b1;
      end
      OpcLui: begin
        dec.imm_type  = 3'd3;
        dec.alu_op    = AluLui;
        dec.reg_write = 1'b1;
      end
      OpcJal: begin
        dec.imm_type  = 3'd4;
        dec.alu_op    = AluAdd;
        dec.rd_src    = 1'b1;
        dec.reg_write = 1'b1;
        dec.branch    = 2'd3;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) dec.alu_op = AluAdd;
    // Only writers carry a destination, so non-writers never match a hazard.
    if (dec.reg_write) dec.rd = id_inst[11:7];
  end

  // Source-register usage and load-use hazard against the EX instruction.
  always_comb begin
    use_rs1 = !(opcode == OpcLui || opcode == OpcAuipc || opcode == OpcJal);
    use_rs2 = (opcode == OpcOp || opcode == OpcStore || opcode == OpcBranch);
    hazard  = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid &&
              ((use_rs1 && rs1 == ex_q.rd) || (use_rs2 && rs2 == ex_q.rd));
    md_load = id_inst[14] ? DivLoad : MulLoad;
  end

  // Next state: flush > MD hold > hazard bubble > decode > bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = ex_q;
    if (flush) begin
      ex_d    = '0;
      state_d = StRun;
      cnt_d   = '0;
    end else if (state_q == StMdWait) begin
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) state_d = StRun;
    end else if (hazard) begin
      ex_d = '0;
    end else if (id_valid) begin
      ex_d = dec;
      if (dec_md) begin
        cnt_d = md_load;
        if (md_load != 6'd0) state_d = StMdWait;
      end
    end else begin
      ex_d = '0;
    end
  end

  // Outputs: stall and busy flags.
  always_comb begin
    md_busy  = (state_q == StMdWait);
    stall_id = ((state_q == StMdWait) && !flush) || ((state_q == StRun) && hazard && !flush);
  end

  // State, counter and ID/EX register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
    end
  end

  assign ex_valid         = ex_q.valid;
  assign ex_imm_type      = ex_q.imm_type;
  assign ex_alu_op        = ex_q.alu_op;
  assign ex_pc_to_reg_src = ex_q.pc_to_reg_src;
  assign ex_rd_src        = ex_q.rd_src;
  assign ex_alu_src       = ex_q.alu_src;
  assign ex_mem_to_reg    = ex_q.mem_to_reg;
  assign ex_mem_write     = ex_q.mem_write;
  assign ex_mem_read      = ex_q.mem_read;
  assign ex_reg_write     = ex_q.reg_write;
  assign ex_branch        = ex_q.branch;
  assign ex_rd            = ex_q.rd;
  assign ex_illegal       = ex_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: directed scenarios then random instruction stream
// compared against a cycle-level reference model of the decode/pipeline rules.
module tb_ctrl_decode_pipe;

  localparam logic [6:0] OP = 7'b0110011, LOAD = 7'b0000011, OPIMM = 7'b0010011;
  localparam logic [6:0] JALR = 7'b1100111, STORE = 7'b0100011, BRANCH = 7'b1100011;
  localparam logic [6:0] AUIPC = 7'b0010111, LUI = 7'b0110111, JAL = 7'b1101111;

  typedef struct packed {
    logic       valid;
    logic [2:0] imm;
    logic [2:0] alu;
    logic       pc2r, rd_src, alu_src, m2r, mw, mr, rw;
    logic [1:0] br;
    logic [4:0] rd;
    logic       ill;
  } bun_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [31:0] id_inst = '0;
  logic flush = 1'b0;

  logic stall_id, ex_valid, ex_pc_to_reg_src, ex_rd_src, ex_alu_src, ex_mem_to_reg;
  logic ex_mem_write, ex_mem_read, ex_reg_write, ex_illegal, md_busy;
  logic [2:0] ex_imm_type, ex_alu_op;
  logic [1:0] ex_branch;
  logic [4:0] ex_rd;

  logic n_ex_illegal, n_ex_reg_write;
  logic [2:0] n_ex_alu_op;
  logic unused_stall, unused_valid, unused_pc2r, unused_rdsrc, unused_alusrc, unused_m2r;
  logic unused_mw, unused_mr, unused_busy;
  logic [2:0] unused_imm;
  logic [1:0] unused_br;
  logic [4:0] unused_rd;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(.EN_MEXT(1'b1), .MUL_CYCLES(1), .DIV_CYCLES(33)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_imm_type(ex_imm_type),
    .ex_alu_op(ex_alu_op), .ex_pc_to_reg_src(ex_pc_to_reg_src), .ex_rd_src(ex_rd_src),
    .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .ex_rd(ex_rd), .ex_illegal(ex_illegal), .md_busy(md_busy)
  );

  ctrl_decode_pipe #(.EN_MEXT(1'b0), .MUL_CYCLES(1), .DIV_CYCLES(33)) dut_nm (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
    .stall_id(unused_stall), .ex_valid(unused_valid), .ex_imm_type(unused_imm),
    .ex_alu_op(n_ex_alu_op), .ex_pc_to_reg_src(unused_pc2r), .ex_rd_src(unused_rdsrc),
    .ex_alu_src(unused_alusrc), .ex_mem_to_reg(unused_m2r), .ex_mem_write(unused_mw),
    .ex_mem_read(unused_mr), .ex_reg_write(n_ex_reg_write), .ex_branch(unused_br),
    .ex_rd(unused_rd), .ex_illegal(n_ex_illegal), .md_busy(unused_busy)
  );

  bun_t ex_obs;
  assign ex_obs = {ex_valid, ex_imm_type, ex_alu_op, ex_pc_to_reg_src, ex_rd_src, ex_alu_src,
                   ex_mem_to_reg, ex_mem_write, ex_mem_read, ex_reg_write, ex_branch, ex_rd,
                   ex_illegal};

  int   total = 0;
  int   bad = 0;
  bun_t m_ex;
  int   m_hold;
  bit   m_stall;
  logic last_stall, last_busy;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Expected bundle straight from the opcode table.
  function automatic bun_t ref_dec(logic [31:0] i, bit mext);
    bun_t b;
    b = '0;
    b.valid = 1'b1;
    case (i[6:0])
      OP: begin
        if (i[31:25] == 7'b0000001 && !mext) b.ill = 1'b1;
        else begin
          b.alu = (i[31:25] == 7'b0000001) ? 3'd6 : 3'd0;
          b.alu_src = 1'b1; b.rw = 1'b1;
        end
      end
      LOAD:   begin b.alu = 3'd2; b.mr = 1'b1; b.m2r = 1'b1; b.rw = 1'b1; end
      OPIMM:  begin b.alu = 3'd1; b.rw = 1'b1; end
      JALR:   begin b.alu = 3'd3; b.rd_src = 1'b1; b.rw = 1'b1; b.br = 2'd2; end
      STORE:  begin b.imm = 3'd1; b.alu = 3'd2; b.mw = 1'b1; end
      BRANCH: begin b.imm = 3'd2; b.alu = 3'd4; b.alu_src = 1'b1; b.br = 2'd1; end
      AUIPC:  begin
        b.imm = 3'd3; b.alu = 3'd2; b.pc2r = 1'b1; b.alu_src = 1'b1; b.rd_src = 1'b1;
        b.rw = 1'b1;
      end
      LUI:    begin b.imm = 3'd3; b.alu = 3'd5; b.rw = 1'b1; end
      JAL:    begin b.imm = 3'd4; b.alu = 3'd2; b.rd_src = 1'b1; b.rw = 1'b1; b.br = 2'd3; end
      default: b.ill = 1'b1;
    endcase
    if (b.ill) b.alu = 3'd2;
    if (b.rw) b.rd = i[11:7];
    return b;
  endfunction

  function automatic bit ref_hazard(bit v, logic [31:0] i);
    bit u1, u2;
    u1 = !(i[6:0] == LUI || i[6:0] == AUIPC || i[6:0] == JAL);
    u2 = (i[6:0] == OP || i[6:0] == STORE || i[6:0] == BRANCH);
    return v && m_ex.valid && m_ex.mr && m_ex.rd != 5'd0 &&
           ((u1 && i[19:15] == m_ex.rd) || (u2 && i[24:20] == m_ex.rd));
  endfunction

  // One cycle: drive ID, check stall/busy mid-cycle, clock, check the EX bundle.
  task automatic step(input bit v, input logic [31:0] i, input bit fl);
    bit hz;
    id_valid = v; id_inst = i; flush = fl;
    #2;
    hz = ref_hazard(v, i);
    m_stall = !fl && (m_hold > 0 || hz);
    last_stall = stall_id;
    last_busy = md_busy;
    chk("stall_id", 32'(stall_id), 32'(m_stall));
    chk("md_busy", 32'(md_busy), 32'(m_hold > 0));
    @(posedge clk);
    if (fl) begin
      m_ex = '0; m_hold = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (hz || !v) begin
      m_ex = '0;
    end else begin
      m_ex = ref_dec(i, 1'b1);
      if (i[6:0] == OP && i[31:25] == 7'b0000001) m_hold = (i[14] ? 33 : 1) - 1;
    end
    #1;
    chk("ex_bundle", 32'(ex_obs), 32'(m_ex));
  endtask

  function automatic logic [31:0] gen_inst();
    logic [6:0] ops [0:9];
    logic [6:0] op, f7;
    int k;
    ops = '{OP, LOAD, OPIMM, JALR, STORE, BRANCH, AUIPC, LUI, JAL, 7'h7f};
    k = int'($urandom_range(0, 10));
    op = (k == 10) ? 7'($urandom) : ops[k];
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'h01;
    endcase
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), op};
  endfunction

  localparam logic [31:0] LW5  = {12'd0, 5'd1, 3'b010, 5'd5, LOAD};
  localparam logic [31:0] LW0  = {12'd0, 5'd1, 3'b010, 5'd0, LOAD};
  localparam logic [31:0] ADD6 = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, OP};
  localparam logic [31:0] ADD6Z = {7'd0, 5'd2, 5'd0, 3'b000, 5'd6, OP};
  localparam logic [31:0] ADD7 = {7'd0, 5'd2, 5'd1, 3'b000, 5'd7, OP};
  localparam logic [31:0] JAL1 = {20'h00100, 5'd1, JAL};
  localparam logic [31:0] BAD  = 32'h0000_00ff;
  localparam logic [31:0] DIV3 = {7'b0000001, 5'd5, 5'd4, 3'b100, 5'd3, OP};
  localparam logic [31:0] MUL1 = {7'b0000001, 5'd3, 5'd2, 3'b000, 5'd1, OP};

  initial begin
    int occ, stalls, busys;
    logic [31:0] cur;
    bit cur_v, fl;
    m_ex = '0; m_hold = 0;
    #1;
    chk("rst_bundle", 32'(ex_obs), 32'd0);
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_busy", 32'(md_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Decode sweep
    step(1'b1, LW5, 1'b0);
    chk("lw_imm", 32'(ex_imm_type), 32'd0);
    chk("lw_alu", 32'(ex_alu_op), 32'd2);
    chk("lw_mr_m2r_rw", 32'({ex_mem_read, ex_mem_to_reg, ex_reg_write}), 32'd7);
    chk("lw_branch", 32'(ex_branch), 32'd0);
    // Load-use on x5
    step(1'b1, ADD6, 1'b0);
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    step(1'b1, ADD6, 1'b0);
    chk("lu_stall_gone", 32'(last_stall), 32'd0);
    chk("lu_add_alu", 32'(ex_alu_op), 32'd0);
    chk("lu_add_rd", 32'(ex_rd), 32'd6);
    // Load to x0 never hazards
    step(1'b1, LW0, 1'b0);
    step(1'b1, ADD6Z, 1'b0);
    chk("lu_x0_nostall", 32'(last_stall), 32'd0);
    chk("lu_x0_valid", 32'(ex_valid), 32'd1);
    step(1'b1, JAL1, 1'b0);
    chk("jal_imm", 32'(ex_imm_type), 32'd4);
    chk("jal_rdsrc", 32'(ex_rd_src), 32'd1);
    chk("jal_branch", 32'(ex_branch), 32'd3);
    step(1'b1, BAD, 1'b0);
    chk("ill_flag", 32'(ex_illegal), 32'd1);
    chk("ill_writes", 32'({ex_reg_write, ex_mem_write}), 32'd0);
    // Flush beats a simultaneous load-use
    step(1'b1, LW5, 1'b0);
    step(1'b1, ADD6, 1'b1);
    chk("fl_stall", 32'(last_stall), 32'd0);
    chk("fl_bubble", 32'(ex_valid), 32'd0);
    // DIV occupancy
    step(1'b1, DIV3, 1'b0);
    occ = 1; stalls = 0; busys = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, ADD7, 1'b0);
      stalls += int'(last_stall);
      busys += int'(last_busy);
      if (!(ex_valid && ex_alu_op == 3'd6)) break;
      occ++;
    end
    chk("div_occupancy", 32'(occ), 32'd33);
    chk("div_stalls", 32'(stalls), 32'd32);
    chk("div_busy", 32'(busys), 32'd32);
    chk("div_next_in_ex", 32'(ex_rd), 32'd7);
    // Single-cycle MUL, and MUL illegal without M
    step(1'b1, MUL1, 1'b0);
    chk("mul_alu", 32'(ex_alu_op), 32'd6);
    chk("nm_mul_illegal", 32'(n_ex_illegal), 32'd1);
    chk("nm_mul_rw", 32'(n_ex_reg_write), 32'd0);
    chk("nm_mul_alu", 32'(n_ex_alu_op), 32'd2);
    step(1'b1, ADD7, 1'b0);
    chk("mul_nostall", 32'(last_stall), 32'd0);
    chk("mul_next_in_ex", 32'(ex_rd), 32'd7);
    // Asynchronous reset in the middle of a DIV hold
    step(1'b1, DIV3, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b1, ADD7, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_div_bundle", 32'(ex_obs), 32'd0);
    chk("rst_mid_div_busy", 32'(md_busy), 32'd0);
    chk("rst_mid_div_stall", 32'(stall_id), 32'd0);
    m_ex = '0; m_hold = 0;
    id_valid = 1'b0; flush = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random stream; ID is held while the model says it is stalled
    cur = gen_inst(); cur_v = 1'b1;
    for (int n = 0; n < 400; n++) begin
      fl = ($urandom_range(0, 9) == 0);
      step(cur_v, cur, fl);
      if (!m_stall) begin
        cur = gen_inst();
        cur_v = ($urandom_range(0, 7) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
- Next-generation main control unit: full 32-bit instruction decode into the RV32I control bundle, plus optional M-extension decode.
- Registers the bundle into the ID/EX pipeline stage itself.
- Detects load-use hazards, sequences multi-cycle MUL/DIV occupancy of EX, and handles branch flush.
- Sits between IF/ID register and the EX datapath; drives IF/ID stall.

Parameters:
- EN_MEXT, 1, 1 = decode OP with funct7=0000001 as MUL/DIV; 0 = treat as illegal
- MUL_CYCLES, 1, EX occupancy cycles for MUL* (funct3[2]=0), range 1..64
- DIV_CYCLES, 33, EX occupancy cycles for DIV*/REM* (funct3[2]=1), range 1..64

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_inst  in  32  instruction in ID
- flush  in  1  taken branch/jump resolved in EX; kill ID
- stall_id  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX bundle valid
- ex_imm_type  out  3  I=0, S=1, B=2, U=3, J=4
- ex_alu_op  out  3  R=0, I=1, ADD=2, JALR=3, B=4, LUI=5, MULDIV=6
- ex_pc_to_reg_src, ex_rd_src, ex_alu_src, ex_mem_to_reg, ex_mem_write, ex_mem_read, ex_reg_write  out  1 each  datapath selects/enables
- ex_branch  out  2  None=0, B=1, JALR=2, J=3
- ex_rd  out  5  destination register of EX instruction
- ex_illegal  out  1  EX instruction undecodable
- md_busy  out  1  multi-cycle MUL/DIV holding EX (not last cycle)

Behaviour:
- Decode, by opcode:
  - OP 0110011: alu=R, alu_src=1, reg_write=1.
  - LOAD 0000011: imm=I, alu=ADD, mem_read=1, mem_to_reg=1, reg_write=1.
  - OP-IMM 0010011: imm=I, alu=I, reg_write=1.
  - JALR 1100111: imm=I, alu=JALR, rd_src=1, reg_write=1, branch=JALR.
  - STORE 0100011: imm=S, alu=ADD, mem_write=1.
  - BRANCH 1100011: imm=B, alu=B, alu_src=1, branch=B.
  - AUIPC 0010111: imm=U, alu=ADD, pc_to_reg_src=1, alu_src=1, rd_src=1, reg_write=1.
  - LUI 0110111: imm=U, alu=LUI, reg_write=1.
  - JAL 1101111: imm=J, alu=ADD, rd_src=1, reg_write=1, branch=J.
  - Unlisted fields are 0.
- OP with funct7=0000001: alu=MULDIV when EN_MEXT=1; otherwise illegal.
- Illegal or unknown opcode: all enables 0, alu=ADD, ex_illegal=1, ex_valid=1.
- Bubble: ex_valid=0; all control, ex_rd, ex_illegal = 0.
- Reset (async, any state, including mid MUL/DIV): bubble in EX, state RUN, counter 0, stall_id=0, md_busy=0.
- Source-register use:
  - rs1 used by all except LUI, AUIPC, JAL.
  - rs2 used by OP, STORE, BRANCH.
- Load-use hazard (combinational): ex_valid & ex_mem_read & ex_rd!=0 & id_valid & used rs matches ex_rd.
- FSM states: RUN, MD_WAIT.
- On the edge loading a MULDIV into EX, 6-bit cnt loads N-1, where N=MUL_CYCLES or DIV_CYCLES.
  - If N-1>0: go to MD_WAIT.
  - In MD_WAIT: cnt decrements each edge; return to RUN on the edge where cnt==1.
- Total EX occupancy is exactly N cycles. md_busy=1 and stall_id=1 in every MD_WAIT cycle.
- Per-edge priority for the EX register:
  1. flush: load bubble. Also aborts MD_WAIT to RUN with cnt=0.
  2. MD_WAIT: hold EX unchanged.
  3. load-use hazard: load bubble.
  4. id_valid: load the decoded bundle.
  5. Otherwise: load bubble.
- stall_id = (MD_WAIT & !flush) | (RUN & load-use hazard & !flush).
- Latency: decode in cycle t appears on ex_* after the edge ending cycle t.

Test Plan:
- Reset mid-DIV (DIV_CYCLES=33, cycle 10 of hold) -> all ex_* =0, md_busy=0 immediately, not waiting for a clock edge.
- Decode sweep: LW x5,0(x1) -> imm=0, alu=2, mem_read=1, mem_to_reg=1, reg_write=1, branch=0; JAL -> imm=4, rd_src=1, branch=3; opcode 1111111 -> ex_illegal=1, no writes.
- Load-use: LW x5 then ADD x6,x5,x2 -> stall_id=1 for 1 cycle, one bubble (ex_valid=0), ADD enters EX next cycle; the same pair with LW x0 -> no stall.
- DIV x3,x4,x5 with DIV_CYCLES=33 -> EX holds 33 cycles, md_busy and stall_id high for 32 cycles, next instruction enters EX on cycle 34; MUL with MUL_CYCLES=1 -> no stall.
- flush asserted with valid ID and simultaneous load-use -> bubble loaded, stall_id=0.
- EN_MEXT=0, MUL x1,x2,x3 -> ex_illegal=1, reg_write=0.
